ram_responder: RTL

Memory-side responder for the processor's MFA/MFC memory handshake. The data path raises MFA with RW, Type, Address and DataIn; this block performs the byte, halfword or word access on a big-endian, byte-addressed RAM after a programmable number of wait states. It then returns MFC, which it holds until MFA is withdrawn. It replaces the zero-latency RAM model, so control-unit wait-for-MFC states are exercised under realistic latency.

---
 rtl/ram_pkg.sv | 30 +++
 rtl/ram_lane_ctl.sv | 33 +++
 rtl/ram_responder.sv | 90 +++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared encodings, FSM state codes and request record for the MFA/MFC RAM responder.
package ram_pkg;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CNT_W     = 4;
    localparam int NUM_LANES = 4;

    typedef struct packed {
        logic        rw;
        logic [1:0]  typ;
        logic [31:0] data;
    } ram_req_t;

    // Low address bits after forcing natural alignment; reserved type behaves as word.
    function automatic logic [1:0] align_lo(input logic [1:0] typ, input logic [1:0] lo);
        case (typ)
            TYPE_BYTE: align_lo = lo;
            TYPE_HALF: align_lo = {lo[1], 1'b0};
            default:   align_lo = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ram_lane_ctl.sv
// Byte-lane steering for a big-endian word: lane k is byte offset k, held in bits 31-8k..24-8k.
module ram_lane_ctl
    import ram_pkg::*;
(
    input  logic [1:0]                  typ,
    input  logic [1:0]                  offs,
    input  logic [31:0]                 wdata,
    input  logic [NUM_LANES-1:0][7:0]   rword,
    output logic [NUM_LANES-1:0]        be,
    output logic [NUM_LANES-1:0][7:0]   wlane,
    output logic [31:0]                 rdata
);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam logic [1:0] K = 2'(k);
        assign be[k] = (typ == TYPE_BYTE) ? (offs == K) :
                       (typ == TYPE_HALF) ? (offs[1] == K[1]) : 1'b1;
        // Narrow writes come from the low bits of DataIn; a halfword's even lane takes the MSB.
        assign wlane[k] = (typ == TYPE_BYTE) ? wdata[7:0] :
                          (typ == TYPE_HALF) ? (K[0] ? wdata[7:0] : wdata[15:8]) :
                                               wdata[8*(NUM_LANES-1-k) +: 8];
    end

    always_comb begin
        rdata = 32'h0;
        case (typ)
            TYPE_BYTE: rdata = {24'h0, rword[offs]};
            TYPE_HALF: rdata = {16'h0, rword[{offs[1], 1'b0}], rword[{offs[1], 1'b1}]};
            default:   rdata = {rword[0], rword[1], rword[2], rword[3]};
        endcase
    end

endmodule

// File: rtl/ram_responder.sv
// Memory-side MFA/MFC responder: latches a request, waits WAIT_STATES cycles, then performs
// a big-endian byte/halfword/word access and holds MFC until MFA is withdrawn.
module ram_responder
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  MFA,
    input  logic                  RW,
    input  logic [1:0]            Type,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MFC
);

    logic [7:0] Mem [0:2**ADDR_WIDTH-1];

    logic [1:0]                 state;
    logic [CNT_W-1:0]           cnt;
    ram_req_t                   req;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic                       access;
    logic [NUM_LANES-1:0][7:0]  rword;
    logic [NUM_LANES-1:0]       be;
    logic [NUM_LANES-1:0][7:0]  wlane;
    logic [31:0]                rdata;

    assign access = (state == WAIT) && (cnt == '0);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_rd
        assign rword[k] = Mem[{addr_q[ADDR_WIDTH-1:2], 2'(k)}];
    end

    ram_lane_ctl u_lane (
        .typ   (req.typ),
        .offs  (addr_q[1:0]),
        .wdata (req.data),
        .rword (rword),
        .be    (be),
        .wlane (wlane),
        .rdata (rdata)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            MFC     <= 1'b0;
            DataOut <= 32'h0;
            req     <= '0;
            addr_q  <= '0;
        end else begin
            case (state)
                IDLE: if (MFA) begin
                    req    <= '{rw: RW, typ: Type, data: DataIn};
                    addr_q <= {Address[ADDR_WIDTH-1:2], align_lo(Type, Address[1:0])};
                    cnt    <= CNT_W'(WAIT_STATES);
                    state  <= WAIT;
                end
                // The access completes even if MFA has already gone away; DONE then drops MFC next edge.
                WAIT: if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    MFC   <= 1'b1;
                    state <= DONE;
                    if (!req.rw) DataOut <= rdata;
                end
                DONE: if (!MFA) begin
                    MFC   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // No reset on the array: contents survive Reset, but a pending write is squashed.
    always_ff @(posedge CLK) begin
        if (!Reset && access && req.rw) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (be[k]) Mem[{addr_q[ADDR_WIDTH-1:2], 2'(k)}] <= wlane[k];
            end
        end
    end

endmodule
